fire_control: RTL
=================

Name: fire_control

Overview:
- Sequencer directly upstream of the ammo saturation counter in the weapons subsystem.
- Converts the pilot's trigger, burst selection and reload requests into single-cycle `fire` (counter down), `load` and `load_max` strobes, plus the latched `fire_rate`.
- Gates firing on attack mode and on sufficient ammo, enforces a programmable cooldown between shots, and raises a one-cycle `error` on refused shots.

Parameters:
- AMMO_W, 9, width of the ammo/rate datapath (matches the counter).
- CD_W, 4, width of the cooldown value.
- BURST_LEN, 3, shots per burst when `burst_en` is set.
- RELOAD_CYCLES, 8, busy cycles after the reload load strobe.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode_selector  in  4  one-hot ship mode; 4'b0010 = attack.
- trigger  in  1  pilot trigger, level; only its rising edge starts an engagement.
- burst_en  in  1  sampled at engagement start: 1 = BURST_LEN shots, 0 = single shot.
- reload_req  in  1  request to refill ammo to `ammo_max_in`.
- fire_rate_in  in  AMMO_W  ammo consumed per shot.
- cooldown_in  in  CD_W  idle cycles between shots.
- ammo_level  in  AMMO_W  counter output (current ammo).
- ammo_max_in  in  AMMO_W  magazine capacity used on reload.
- fire  out  1  one-cycle down strobe to the counter.
- fire_rate  out  AMMO_W  rate latched at engagement start, drives the counter rate.
- load  out  1  one-cycle load strobe to the counter.
- load_max  out  2  one-hot max-register select: 2'b10 load new max, 2'b01 hold.
- ammo_in  out  AMMO_W  value presented to the counter `in`.
- busy  out  1  high in any state other than IDLE.
- error  out  1  one-cycle refused-shot pulse.

Behaviour:
- All outputs are registered. Reset values: state IDLE, fire 0, load 0, load_max 2'b01, ammo_in 0, fire_rate 0, busy 0, error 0, trig_d 0.
- `rst` mid-operation aborts any burst, cooldown or reload at the next edge; no error is raised.
- Edge detect: `trig_rise = trigger & ~trig_d`, with `trig_d` registered every cycle.
- `armed = (mode_selector == 4'b0010)`, exact match; any other pattern, including multi-hot, is unarmed.
- `ok = armed & (fire_rate != 0) & (ammo_level >= fire_rate)`, unsigned compare.
- States: IDLE, FIRE, COOL, RELOAD.
- IDLE, priority order:
  - `reload_req` → RELOAD. `reload_req` wins over a simultaneous `trig_rise`, and no error is raised.
  - else `trig_rise` → latch `fire_rate <= fire_rate_in`, `cd <= cooldown_in`, `shots <= burst_en ? BURST_LEN : 1`. If `armed & fire_rate_in != 0 & ammo_level >= fire_rate_in` → FIRE; else pulse error and stay in IDLE.
- FIRE: exactly one cycle.
  - `fire = 1` in this cycle; `shots` decrements.
  - Next state is always COOL.
- COOL: lasts `cd + 1` cycles (minimum 1), so `ammo_level` reflects the previous shot before it is re-checked. On the last COOL cycle:
  - `shots == 0` → IDLE.
  - `~armed` → IDLE; burst abandoned silently.
  - `ok` → FIRE.
  - otherwise (ammo exhausted mid-burst) → error pulse, then IDLE.
- RELOAD:
  - First cycle: `load = 1`, `load_max = 2'b10`, `ammo_in = ammo_max_in`.
  - Then `load = 0`, `load_max = 2'b01`, and the block stays RELOAD_CYCLES cycles before returning to IDLE.
  - `trig_rise` during RELOAD, FIRE or COOL → error pulse; state unaffected.
- `fire` and `load` are never high in the same cycle.
- `fire_rate` holds its latched value outside engagements.

Test Plan:
- Reset with all inputs 0 → all outputs at reset values, busy 0; `rst` asserted during COOL returns IDLE next edge with fire never pulsing again.
- Attack mode 0010, `ammo_level` 500, `fire_rate_in` 1, `cooldown_in` 2, `burst_en` 0, one trigger rise → exactly one `fire` pulse 1 cycle after the rise, busy for 4 cycles, no error.
- Same setup with `burst_en` 1 → 3 `fire` pulses spaced 4 cycles apart (1 FIRE + 3 COOL); holding trigger high produces no further bursts.
- Mode 0100, trigger rise → error high exactly 1 cycle, fire never asserted, state IDLE.
- `ammo_level` 5, `fire_rate_in` 3, burst of 3 with counter model → first shot fires, second is refused with an error pulse after cooldown, block returns IDLE.
- `reload_req` with `ammo_max_in` 500, and a simultaneous trigger rise → load=1 and load_max=10 with ammo_in=500 for one cycle, busy for 1+8 cycles, no fire, no error; a trigger during RELOAD → error pulse only.

Source files
------------

// File: rtl/fire_control.sv
// fire_control: engagement sequencer sitting in front of the ammo
// saturation counter. Turns trigger / burst / reload requests into
// single-cycle fire and load strobes, and latches the per-shot rate.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   mode_selector   : one-hot ship mode, 4'b0010 = attack (armed)
//   trigger         : pilot trigger level; rising edge starts an engagement
//   burst_en        : sampled at engagement start, BURST_LEN shots vs one
//   reload_req      : refill request, handled only while idle
//   fire_rate_in    : ammo consumed per shot
//   cooldown_in     : idle cycles between shots
//   ammo_level      : current ammo from the counter
//   ammo_max_in     : magazine capacity written on reload
//   fire            : one-cycle down strobe to the counter
//   fire_rate       : rate latched at engagement start
//   load            : one-cycle load strobe to the counter
//   load_max        : 2'b10 load new max, 2'b01 hold
//   ammo_in         : value presented to the counter input
//   busy            : high whenever not idle
//   error           : one-cycle refused-shot pulse
module fire_control #(
  parameter int unsigned AMMO_W        = 9,
  parameter int unsigned CD_W          = 4,
  parameter int unsigned BURST_LEN     = 3,
  parameter int unsigned RELOAD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mode_selector,
  input  logic              trigger,
  input  logic              burst_en,
  input  logic              reload_req,
  input  logic [AMMO_W-1:0] fire_rate_in,
  input  logic [CD_W-1:0]   cooldown_in,
  input  logic [AMMO_W-1:0] ammo_level,
  input  logic [AMMO_W-1:0] ammo_max_in,
  output logic              fire,
  output logic [AMMO_W-1:0] fire_rate,
  output logic              load,
  output logic [1:0]        load_max,
  output logic [AMMO_W-1:0] ammo_in,
  output logic              busy,
  output logic              error
);

  localparam int unsigned SHOT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned RL_W   = (RELOAD_CYCLES > 0) ? $clog2(RELOAD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_COOL,
    S_RELOAD
  } state_t;

  state_t            state, state_n;
  logic              trig_d;
  logic [CD_W-1:0]   cd, cd_n;
  logic [CD_W-1:0]   cool_cnt, cool_n;
  logic [SHOT_W-1:0] shots, shots_n;
  logic [RL_W-1:0]   rl_cnt, rl_n;

  logic              fire_n, load_n, busy_n, error_n;
  logic [1:0]        load_max_n;
  logic [AMMO_W-1:0] ammo_in_n, fire_rate_n;

  logic trig_rise, armed, ok_new, ok_latched;

  assign trig_rise  = trigger & ~trig_d;
  assign armed      = (mode_selector == 4'b0010);
  assign ok_new     = armed & (fire_rate_in != '0) & (ammo_level >= fire_rate_in);
  assign ok_latched = armed & (fire_rate != '0) & (ammo_level >= fire_rate);

  // Strobes are registered: each one is raised on the edge that enters the
  // state it belongs to, so fire is high exactly while the state is FIRE.
  always_comb begin
    state_n     = state;
    cd_n        = cd;
    cool_n      = cool_cnt;
    shots_n     = shots;
    rl_n        = rl_cnt;
    fire_n      = 1'b0;
    load_n      = 1'b0;
    load_max_n  = 2'b01;
    ammo_in_n   = ammo_in;
    fire_rate_n = fire_rate;
    error_n     = 1'b0;

    case (state)
      S_IDLE: begin
        if (reload_req) begin
          state_n    = S_RELOAD;
          load_n     = 1'b1;
          load_max_n = 2'b10;
          ammo_in_n  = ammo_max_in;
          rl_n       = RL_W'(RELOAD_CYCLES);
        end else if (trig_rise) begin
          fire_rate_n = fire_rate_in;
          cd_n        = cooldown_in;
          shots_n     = burst_en ? SHOT_W'(BURST_LEN) : SHOT_W'(1);
          if (ok_new) begin
            state_n = S_FIRE;
            fire_n  = 1'b1;
          end else begin
            error_n = 1'b1;
          end
        end
      end

      S_FIRE: begin
        shots_n = shots - SHOT_W'(1);
        cool_n  = cd;
        state_n = S_COOL;
      end

      S_COOL: begin
        if (cool_cnt != '0) begin
          cool_n = cool_cnt - CD_W'(1);
        end else if ((shots == '0) || !armed) begin
          state_n = S_IDLE;
        end else if (ok_latched) begin
          state_n = S_FIRE;
          fire_n  = 1'b1;
        end else begin
          state_n = S_IDLE;
          error_n = 1'b1;
        end
      end

      S_RELOAD: begin
        if (rl_cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          rl_n = rl_cnt - RL_W'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase

    if ((state != S_IDLE) && trig_rise) begin
      error_n = 1'b1;
    end

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      trig_d    <= 1'b0;
      cd        <= '0;
      cool_cnt  <= '0;
      shots     <= '0;
      rl_cnt    <= '0;
      fire      <= 1'b0;
      load      <= 1'b0;
      load_max  <= 2'b01;
      ammo_in   <= '0;
      fire_rate <= '0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      trig_d    <= trigger;
      cd        <= cd_n;
      cool_cnt  <= cool_n;
      shots     <= shots_n;
      rl_cnt    <= rl_n;
      fire      <= fire_n;
      load      <= load_n;
      load_max  <= load_max_n;
      ammo_in   <= ammo_in_n;
      fire_rate <= fire_rate_n;
      busy      <= busy_n;
      error     <= error_n;
    end
  end

endmodule
